// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package md_sequencer_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned URA_W  = 7;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    localparam logic [URA_W-1:0] URA_HI = 7'b1000000;
    localparam logic [URA_W-1:0] URA_LO = 7'b1000001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    function automatic logic is_mult_op(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        return op <= MD_MTLO;
    endfunction

endpackage

// File: rtl/md_datapath.sv
// Combinational 64-bit product and quotient/remainder, signed or unsigned.
module md_datapath (
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic [63:0]        a_ext;
    logic [63:0]        b_ext;
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [32:0] sq;
    logic signed [32:0] sr;
    logic [31:0]        uq;
    logic [31:0]        ur;

    // 33-bit signed operands keep -2^31 / -1 well defined (wraps to 0x80000000).
    always_comb begin
        a_ext    = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        b_ext    = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        prod     = a_ext * b_ext;
        div_zero = (b == 32'b0);
        sa       = $signed({a[31], a});
        sb       = $signed({b[31], b});
        sq       = '0;
        sr       = '0;
        uq       = '0;
        ur       = '0;
        if (!div_zero) begin
            sq = sa / sb;
            sr = sa % sb;
            uq = a / b;
            ur = a % b;
        end
        quot = is_signed ? sq[31:0] : uq;
        rem  = is_signed ? sr[31:0] : ur;
    end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide controller: counts out fixed latency, then commits HI/LO.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        cancel,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_read,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t          state;
    logic [CNT_W-1:0]   count;
    logic [31:0]        hi_n;
    logic [31:0]        lo_n;
    logic               accept;
    logic               is_signed;
    logic [63:0]        prod;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic               div_zero;

    assign accept    = start && !cancel && !busy && is_valid_op(op);
    assign stall     = md_read && (busy || accept);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    md_datapath u_datapath (
        .is_signed (is_signed),
        .a         (src_a),
        .b         (src_b),
        .prod      (prod),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    // Result parks in the shadow pair; architectural HI/LO move only at commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op == MD_MTHI) begin
                            hi <= src_a;
                        end else if (op == MD_MTLO) begin
                            lo <= src_a;
                        end else if (is_mult_op(op)) begin
                            hi_n  <= prod[63:32];
                            lo_n  <= prod[31:0];
                            count <= CNT_W'(MULT_CYCLES);
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end else if (is_div_op(op)) begin
                            // Divide by zero recommits the current values.
                            hi_n  <= div_zero ? hi : rem;
                            lo_n  <= div_zero ? lo : quot;
                            count <= CNT_W'(DIV_CYCLES);
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (count == CNT_W'(1)) begin
                        hi    <= hi_n;
                        lo    <= lo_n;
                        count <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer against an arithmetic reference model.
module tb_md_sequencer;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int BOUND  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_read;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;

    always #5 clk = ~clk;

    md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .cancel  (cancel),
        .src_a   (src_a),
        .src_b   (src_b),
        .md_read (md_read),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    // Reference: architectural effect of one accepted operation.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sp, sq, sr;
        longint unsigned up;
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (o)
            3'd0: begin sp = longint'(sa) * longint'(sb); m_hi = sp[63:32]; m_lo = sp[31:0]; end
            3'd1: begin up = {32'b0, a} * {32'b0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd2: if (b != 0) begin
                sq = longint'(sa) / longint'(sb);
                sr = longint'(sa) % longint'(sb);
                m_lo = sq[31:0];
                m_hi = sr[31:0];
            end
            3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int busy_len(input logic [2:0] o);
        if (o <= 3'd1) return MULT_N;
        if (o <= 3'd3) return DIV_N;
        return 0;
    endfunction

    // Starts at a negedge: drives one start cycle, then counts busy cycles (bounded).
    task automatic issue_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic c, output int cycles);
        start = 1'b1; op = o; src_a = a; src_b = b; cancel = c;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        cycles = 0;
        while (busy && cycles < BOUND) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; op = 0; cancel = 0; src_a = 0; src_b = 0; md_read = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset: busy=%b stall=%b hi=%h lo=%h required 0/0/0/0", busy, stall, hi, lo);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        int cyc;
        issue_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, cyc);
        n_cmp++;
        if (cyc !== MULT_N) begin n_err++; $display("FAIL mult_busy: got %0d required %0d", cyc, MULT_N); end
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            n_err++; $display("FAIL mult_result: hi=%h lo=%h required ffffffff fffffffa", hi, lo);
        end
        model_op(3'd0, 32'hFFFFFFFE, 32'd3);
    endtask

    task automatic test_multu();
        int cyc;
        issue_op(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, cyc);
        n_cmp++;
        if (cyc !== MULT_N) begin n_err++; $display("FAIL multu_busy: got %0d required %0d", cyc, MULT_N); end
        n_cmp++;
        if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
            n_err++; $display("FAIL multu_result: hi=%h lo=%h required 00000002 fffffffa", hi, lo);
        end
        model_op(3'd1, 32'hFFFFFFFE, 32'd3);
    endtask

    task automatic test_div();
        int cyc;
        issue_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, cyc);
        n_cmp++;
        if (cyc !== DIV_N) begin n_err++; $display("FAIL div_busy: got %0d required %0d", cyc, DIV_N); end
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_err++; $display("FAIL div_result: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
        end
        model_op(3'd2, 32'hFFFFFFF9, 32'd2);
        // divu by zero: full latency, registers untouched
        issue_op(3'd3, 32'h12345678, 32'd0, 1'b0, cyc);
        n_cmp++;
        if (cyc !== DIV_N) begin n_err++; $display("FAIL div0_busy: got %0d required %0d", cyc, DIV_N); end
        n_cmp++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            n_err++; $display("FAIL div0_result: hi=%h lo=%h required ffffffff fffffffd", hi, lo);
        end
    endtask

    task automatic test_mtlo();
        int cyc;
        issue_op(3'd5, 32'h00001234, 32'h0, 1'b0, cyc);
        n_cmp++;
        if (cyc !== 0 || lo !== 32'h00001234 || hi !== m_hi) begin
            n_err++; $display("FAIL mtlo: busy_cycles=%0d lo=%h hi=%h required 0 00001234 %h", cyc, lo, hi, m_hi);
        end
        model_op(3'd5, 32'h00001234, 32'h0);
        issue_op(3'd4, 32'hCAFEF00D, 32'h0, 1'b0, cyc);
        n_cmp++;
        if (cyc !== 0 || hi !== 32'hCAFEF00D || lo !== m_lo) begin
            n_err++; $display("FAIL mthi: busy_cycles=%0d hi=%h lo=%h required 0 cafef00d %h", cyc, hi, lo, m_lo);
        end
        model_op(3'd4, 32'hCAFEF00D, 32'h0);
    endtask

    task automatic test_stall();
        int bad;
        md_read = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL stall_idle: got %b required 0", stall); end
        start = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'd9; cancel = 1'b0;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL stall_accept: got %b required 1", stall); end
        @(negedge clk);
        start = 1'b0;
        bad = 0;
        for (int i = 0; i < MULT_N; i++) begin
            #1;
            if (stall !== 1'b1 || busy !== 1'b1) bad++;
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL stall_busy: %0d cycles without stall required 0", bad); end
        n_cmp++;
        if (stall !== 1'b0 || busy !== 1'b0 || lo !== 32'd63 || hi !== 32'd0) begin
            n_err++; $display("FAIL stall_release: stall=%b busy=%b lo=%h hi=%h required 0 0 0000003f 0", stall, busy, lo, hi);
        end
        model_op(3'd0, 32'd7, 32'd9);
        md_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cancel();
        int cyc;
        issue_op(3'd2, 32'd100, 32'd7, 1'b1, cyc);
        n_cmp++;
        if (cyc !== 0 || hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL cancel: busy_cycles=%0d hi=%h lo=%h required 0 %h %h", cyc, hi, lo, m_hi, m_lo);
        end
        // reset during the third busy cycle of a mult
        start = 1'b1; op = 3'd1; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++; $display("FAIL reset_mid: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0; m_lo = 0;
        repeat (MULT_N + 3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_err++; $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h required 0 0 0", busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start = 1'b1; op = 3'd0; src_a = 32'd1000; src_b = 32'hFFFFFFFD; cancel = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 3'd4; src_a = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        cyc = 2;
        while (busy && cyc < BOUND) begin cyc++; @(negedge clk); end
        model_op(3'd0, 32'd1000, 32'hFFFFFFFD);
        n_cmp++;
        if (cyc !== MULT_N + 1 || hi !== m_hi || lo !== m_lo) begin
            n_err++; $display("FAIL b2b_ignore: cycles=%0d hi=%h lo=%h required %0d %h %h", cyc - 1, hi, lo, MULT_N, m_hi, m_lo);
        end
        issue_op(3'd3, 32'd1000, 32'd7, 1'b0, cyc);
        model_op(3'd3, 32'd1000, 32'd7);
        n_cmp++;
        if (cyc !== DIV_N || hi !== 32'd6 || lo !== 32'd142) begin
            n_err++; $display("FAIL b2b_div: cycles=%0d hi=%h lo=%h required %0d 6 8e", cyc, hi, lo, DIV_N);
        end
    endtask

    task automatic test_random();
        int cyc, errs;
        logic [2:0] o;
        logic [31:0] a, b;
        logic c;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h80000000;
            if ($urandom_range(0, 9) == 0) b = 32'hFFFFFFFF;
            c = ($urandom_range(0, 5) == 0);
            issue_op(o, a, b, c, cyc);
            if (!c && o <= 3'd5) model_op(o, a, b);
            n_cmp++;
            if (cyc !== ((c || o > 3'd5) ? 0 : busy_len(o)) || hi !== m_hi || lo !== m_lo) begin
                n_err++; errs++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h cancel=%b: cycles=%0d hi=%h lo=%h required hi=%h lo=%h",
                         i, o, a, b, c, cyc, hi, lo, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mtlo();
        test_stall();
        test_cancel();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
